// File: rtl/riscv_defs.sv
// Shared RV32I core definitions: datapath width, reset PC, bubble instruction
// and the fetch-stage state encoding.
package riscv_defs;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;
  localparam fetch_state_t ST_DROP  = 2'd3;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_stage_if #(
  parameter int XLEN = riscv_defs::XLEN
);

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: {pc, instr, valid} with flush-to-NOP, stall-hold,
// load, and a bubble whenever nothing new arrives.
module if_id_reg #(
  parameter int          XLEN      = riscv_defs::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_defs::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  // The PC field is left alone on flush and bubble; only valid/instr matter there.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (load) begin
      pc_d    = load_pc;
      instr_d = load_instr;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign ifid_pc    = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem handshake FSM, stall hold buffer
// and flush redirect, feeding the IF/ID pipeline register.
module if_fetch_stage #(
  parameter int              XLEN      = riscv_defs::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = riscv_defs::RESET_PC,
  parameter logic [31:0]     NOP_INSTR = riscv_defs::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          pc_next,
  input  logic                     flush,
  input  logic                     stall,
  if_fetch_stage_if.master         imem,
  output logic [XLEN-1:0]          pc_plus4,
  output logic [XLEN-1:0]          ifid_pc,
  output logic [31:0]              ifid_instr,
  output logic                     ifid_valid
);

  import riscv_defs::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] redirect_q, redirect_d;

  logic            ifid_load;
  logic [XLEN-1:0] ifid_load_pc;
  logic [31:0]     ifid_load_instr;

  assign imem.addr = pc_q;
  assign imem.req  = (state_q == ST_FETCH) || (state_q == ST_DROP);
  assign pc_plus4  = pc_q + XLEN'(4);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    hold_pc_d       = hold_pc_q;
    hold_instr_d    = hold_instr_q;
    redirect_d      = redirect_q;
    ifid_load       = 1'b0;
    ifid_load_pc    = pc_q;
    ifid_load_instr = imem.rdata;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem.ack) begin
          if (flush) begin
            pc_d = pc_next;
          end else if (stall) begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem.rdata;
            state_d      = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_next;
          end
        end else if (flush) begin
          // The memory still owes us this beat, so park the target and drain it.
          redirect_d = pc_next;
          state_d    = ST_DROP;
        end
      end
      ST_DROP: begin
        if (flush) redirect_d = pc_next;
        if (imem.ack) begin
          pc_d    = flush ? pc_next : redirect_q;
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          pc_d    = pc_next;
          state_d = ST_FETCH;
        end else if (!stall) begin
          ifid_load       = 1'b1;
          ifid_load_pc    = hold_pc_q;
          ifid_load_instr = hold_instr_q;
          pc_d            = pc_next;
          state_d         = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      redirect_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      redirect_q   <= redirect_d;
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .stall      (stall),
    .load       (ifid_load),
    .load_pc    (ifid_load_pc),
    .load_instr (ifid_load_instr),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr),
    .ifid_valid (ifid_valid)
  );

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RV32I core.
- Owns the PC register and produces pc_plus4, which drives input A of the PC-select 2:1 mux.
- Consumes that mux's output as pc_next.
- Runs the instruction-memory request/acknowledge handshake and drives the IF/ID pipeline register, with stall and flush from the hazard/branch logic.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  single core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_next  input  XLEN  output of the PC-select 2:1 mux (pc_plus4 or branch/jump target).
- flush  input  1  taken branch/jump from EX; pc_next holds the target this cycle.
- stall  input  1  load-use stall from the hazard unit; freeze IF/ID and PC.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  XLEN  fetch address; stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  input  32  fetched instruction.
- pc_plus4  output  XLEN  pc+4, combinational, to mux input A.
- ifid_pc  output  XLEN  IF/ID register: PC of held instruction.
- ifid_instr  output  32  IF/ID register: instruction.
- ifid_valid  output  1  IF/ID register holds a real instruction.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, hold and redirect registers = 0. Reset mid-fetch abandons any outstanding request; a late ack in IDLE is ignored.
- imem_addr=pc, and pc_plus4=pc+4 with wrap modulo 2^XLEN, both at all times.
- States: IDLE, FETCH, HOLD, DROP.
- IDLE: imem_req=0; go to FETCH the next cycle.
- FETCH: imem_req=1. The ack may arrive in any cycle with req=1, including the first.
  - ack & flush: discard rdata; pc<=pc_next; stay in FETCH.
  - ack & stall (no flush): rdata and pc go to hold buffer; go to HOLD; PC unchanged.
  - ack, neither: IF/ID<={pc, rdata, valid=1}; pc<=pc_next; stay in FETCH.
  - no ack & flush: redirect<=pc_next; go to DROP. The request stays up at the old address because the memory must complete it.
- DROP: imem_req=1, addr=old pc.
  - flush again: redirect<=pc_next.
  - on ack: discard rdata; pc<=redirect, or pc_next if flush is asserted that same cycle; go to FETCH.
- HOLD: imem_req=0.
  - flush: discard buffer; pc<=pc_next; go to FETCH.
  - stall deasserts: IF/ID<=hold buffer with valid=1; pc<=pc_next; go to FETCH.
- IF/ID update rule, evaluated each cycle:
  - flush: ifid_valid<=0, ifid_instr<=NOP_INSTR.
  - else stall: hold.
  - else new instruction: load it.
  - else bubble: valid<=0, instr<=NOP_INSTR, pc unchanged.
- Priority: rst > flush > stall > ack.
- Throughput: one instruction per cycle when ack is same-cycle. No instruction is lost or duplicated across stall/flush.
- rdata is registered. pc_plus4 is the only combinational output.

Decomposition:
- Shared package/header riscv_defs holds XLEN, NOP_INSTR, RESET_PC default and the fetch state encoding (2-bit: IDLE=0, FETCH=1, HOLD=2, DROP=3).
- One sub-module, if_id_reg: a register of {pc, instr, valid} with synchronous rst, flush-to-NOP, stall-hold and load enable.
- The FSM, PC and hold buffer live in the top module.

Test Plan:
- Reset release, memory acks the same cycle it sees req: imem_addr=0,4,8,… on consecutive cycles; ifid_pc lags the address by one cycle; ifid_valid=1 continuously from the second fetch cycle.
- Ack 2 cycles after req, pc=0x10: req is held 3 cycles with addr=0x10; IF/ID gets {0x10, rdata}; the next addr is 0x14; ifid_valid=0 in the wait cycles.
- Stall asserted for 3 cycles in the ack cycle at pc=0x20: HOLD entered, imem_req=0, IF/ID frozen. When stall drops, IF/ID gets {0x20, instr} and the next fetch is 0x24.
- Flush with pc_next=0x100 while a fetch at 0x40 awaits ack, ack 2 cycles later: 0x40 data discarded; the next imem_addr is 0x100; ifid_valid=0 after the flush; no 0x40 instruction ever appears.
- Flush and stall together in the ack cycle, pc_next=0x200: flush wins, IF/ID becomes NOP with valid=0, and the next fetch is at 0x200.
- rst asserted mid-FETCH with a stray ack the next cycle: all outputs return to reset values; the ack is ignored; fetch restarts at RESET_PC.
